// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - host-visible register bank with per-bit host/hardware ownership and W1C interrupts
// Optional shadow registers with COMMIT staging are enabled by REG_BANK_SHADOW_EN.
`timescale 1ns/1ps
module reg_bank #(
   parameter int NumRegs = 8,
   parameter int DataWidth = 16,
   parameter int AddrWidth = 4,
   parameter int NumIrq = 4,
   parameter logic [NumRegs*DataWidth-1:0] ResetValues = '0,
   parameter logic [NumRegs*DataWidth-1:0] HostMask = '1
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [AddrWidth-1:0]           addr_i,
   input  logic [DataWidth-1:0]           wdata_i,
   input  logic                           wr_i,
   input  logic                           rd_i,
   output logic [DataWidth-1:0]           rdata_o,
   output logic                           rvalid_o,
   output logic                           ack_o,
   output logic                           err_o,
   input  logic [NumRegs-1:0]             hw_we_i,
   input  logic [NumRegs*DataWidth-1:0]   hw_data_i,
   output logic [NumRegs*DataWidth-1:0]   regs_o,
   input  logic [NumIrq-1:0]              irq_src_i,
   output logic                           irq_o
);
   localparam int RegBits = NumRegs * DataWidth;
   localparam logic [AddrWidth-1:0] IrqStatAddr = AddrWidth'(NumRegs);
   localparam logic [AddrWidth-1:0] IrqEnAddr = AddrWidth'(NumRegs + 1);
`ifdef REG_BANK_SHADOW_EN
   localparam logic [AddrWidth-1:0] CommitAddr = AddrWidth'(NumRegs + 2);
`endif

   logic [RegBits-1:0]   regs_q, regs_d;
   logic [NumIrq-1:0]    irq_stat_q, irq_stat_d;
   logic [NumIrq-1:0]    irq_en_q, irq_en_d;
   logic [NumIrq-1:0]    src_q, src_d;
   logic [DataWidth-1:0] rdata_q, rdata_d;
   logic                 rvalid_q, rvalid_d;
   logic                 ack_q, ack_d;
   logic                 err_q, err_d;
   logic                 irq_q, irq_d;
   logic                 mapped, wr_ok, rd_ok;
   logic [NumIrq-1:0]    irq_edge;
`ifdef REG_BANK_SHADOW_EN
   logic [RegBits-1:0]   shadow_q, shadow_d;
   logic                 commit_q, commit_d;
`endif

   always_comb begin
      mapped = (addr_i < IrqStatAddr) || (addr_i == IrqStatAddr) || (addr_i == IrqEnAddr);
`ifdef REG_BANK_SHADOW_EN
      mapped = mapped || (addr_i == CommitAddr);
`endif
      wr_ok = wr_i && !rd_i && mapped;
      rd_ok = rd_i && !wr_i && mapped;
      // Any strobe that is neither a clean write nor a clean read is an error.
      err_d = (wr_i || rd_i) && !(wr_ok || rd_ok);
      ack_d = wr_ok;
      rvalid_d = rd_ok;

      regs_d = regs_q;
`ifdef REG_BANK_SHADOW_EN
      shadow_d = shadow_q;
      commit_d = wr_ok && (addr_i == CommitAddr) && wdata_i[0];
`endif
      for (int k = 0; k < NumRegs; k++) begin
`ifdef REG_BANK_SHADOW_EN
         if (wr_ok && addr_i == AddrWidth'(k))
            shadow_d[k*DataWidth +: DataWidth] =
               (shadow_q[k*DataWidth +: DataWidth] & ~HostMask[k*DataWidth +: DataWidth]) |
               (wdata_i & HostMask[k*DataWidth +: DataWidth]);
         if (hw_we_i[k])
            shadow_d[k*DataWidth +: DataWidth] =
               (shadow_d[k*DataWidth +: DataWidth] & HostMask[k*DataWidth +: DataWidth]) |
               (hw_data_i[k*DataWidth +: DataWidth] & ~HostMask[k*DataWidth +: DataWidth]);
         if (commit_q)
            regs_d[k*DataWidth +: DataWidth] =
               (regs_q[k*DataWidth +: DataWidth] & ~HostMask[k*DataWidth +: DataWidth]) |
               (shadow_q[k*DataWidth +: DataWidth] & HostMask[k*DataWidth +: DataWidth]);
`else
         if (wr_ok && addr_i == AddrWidth'(k))
            regs_d[k*DataWidth +: DataWidth] =
               (regs_q[k*DataWidth +: DataWidth] & ~HostMask[k*DataWidth +: DataWidth]) |
               (wdata_i & HostMask[k*DataWidth +: DataWidth]);
`endif
         // Host and hardware own disjoint bits, so applying both in sequence never collides.
         if (hw_we_i[k])
            regs_d[k*DataWidth +: DataWidth] =
               (regs_d[k*DataWidth +: DataWidth] & HostMask[k*DataWidth +: DataWidth]) |
               (hw_data_i[k*DataWidth +: DataWidth] & ~HostMask[k*DataWidth +: DataWidth]);
      end

      rdata_d = '0;
      if (rd_ok) begin
         for (int k = 0; k < NumRegs; k++) begin
            if (addr_i == AddrWidth'(k)) begin
`ifdef REG_BANK_SHADOW_EN
               rdata_d = shadow_q[k*DataWidth +: DataWidth];
`else
               rdata_d = regs_q[k*DataWidth +: DataWidth];
`endif
            end
         end
         if (addr_i == IrqStatAddr) rdata_d = DataWidth'(irq_stat_q);
         if (addr_i == IrqEnAddr) rdata_d = DataWidth'(irq_en_q);
      end

      src_d = irq_src_i;
      irq_edge = irq_src_i & ~src_q;
      irq_stat_d = irq_stat_q;
      irq_en_d = irq_en_q;
      if (wr_ok && addr_i == IrqStatAddr) irq_stat_d = irq_stat_q & ~wdata_i[NumIrq-1:0];
      if (wr_ok && addr_i == IrqEnAddr) irq_en_d = wdata_i[NumIrq-1:0];
      // Set is applied after the clear so a simultaneous new edge wins.
      irq_stat_d = irq_stat_d | irq_edge;
      irq_d = |(irq_stat_q & irq_en_q);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         regs_q     <= ResetValues;
         irq_stat_q <= '0;
         irq_en_q   <= '0;
         src_q      <= '0;
         rdata_q    <= '0;
         rvalid_q   <= 1'b0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         irq_q      <= 1'b0;
`ifdef REG_BANK_SHADOW_EN
         shadow_q   <= ResetValues;
         commit_q   <= 1'b0;
`endif
      end else begin
         regs_q     <= regs_d;
         irq_stat_q <= irq_stat_d;
         irq_en_q   <= irq_en_d;
         src_q      <= src_d;
         rdata_q    <= rdata_d;
         rvalid_q   <= rvalid_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         irq_q      <= irq_d;
`ifdef REG_BANK_SHADOW_EN
         shadow_q   <= shadow_d;
         commit_q   <= commit_d;
`endif
      end
   end

   assign regs_o   = regs_q;
   assign rdata_o  = rdata_q;
   assign rvalid_o = rvalid_q;
   assign ack_o    = ack_q;
   assign err_o    = err_q;
   assign irq_o    = irq_q;
endmodule
